// File: rtl/mpsoc_ahb3_ram_pkg.sv
// Shared AHB3-Lite encodings and bridge FSM state codes for the AHB-to-RAM bridge.
package mpsoc_ahb3_ram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_B8    = 3'd0;
  localparam logic [2:0] HSIZE_B16   = 3'd1;
  localparam logic [2:0] HSIZE_B32   = 3'd2;
  localparam logic [2:0] HSIZE_B64   = 3'd3;
  localparam logic [2:0] HSIZE_B128  = 3'd4;
  localparam logic [2:0] HSIZE_B256  = 3'd5;
  localparam logic [2:0] HSIZE_B512  = 3'd6;
  localparam logic [2:0] HSIZE_B1024 = 3'd7;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WR    = 3'd1;
  localparam state_t ST_RD    = 3'd2;
  localparam state_t ST_STALL = 3'd3;
  localparam state_t ST_ERR1  = 3'd4;
  localparam state_t ST_ERR2  = 3'd5;

endpackage

// File: rtl/mpsoc_ahb3_ram_be_gen.sv
// Byte-lane mask from HSIZE and low address bits; flags sizes wider than the bus.
module mpsoc_ahb3_ram_be_gen
  import mpsoc_ahb3_ram_pkg::*;
#(
  parameter int unsigned BYTES = 4,
  parameter int unsigned OFS_W = 2
) (
  input  logic [2:0]       hsize,
  input  logic [OFS_W-1:0] addr_lo,
  output logic [BYTES-1:0] be,
  output logic             size_err
);

  int unsigned nbytes;
  int unsigned ofs;

  // Offset is aligned down to the transfer size so misaligned addresses stay in-lane.
  always_comb begin
    nbytes   = 32'(1) << hsize;
    size_err = (nbytes > BYTES);
    ofs      = (BYTES > 1) ? (32'(addr_lo) & ~(nbytes - 32'(1))) : 32'(0);
    be       = '0;
    if (!size_err) begin
      for (int i = 0; i < int'(BYTES); i++) begin
        if (32'(i) >= ofs && 32'(i) < ofs + nbytes) be[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpsoc_ahb3_ram_bridge.sv
// AHB3-Lite slave driving a 1R1W RAM; stalls a read one cycle on a write hazard,
// or forwards write data instead when MPSOC_AHB3_RAM_BRIDGE_BYPASS_EN is defined.
module mpsoc_ahb3_ram_bridge
  import mpsoc_ahb3_ram_pkg::*;
#(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32,
  parameter int unsigned MEM_ABITS  = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    HSEL,
  input  logic [HADDR_SIZE-1:0]   HADDR,
  input  logic [HDATA_SIZE-1:0]   HWDATA,
  output logic [HDATA_SIZE-1:0]   HRDATA,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [1:0]              HTRANS,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [MEM_ABITS-1:0]    mem_waddr_o,
  output logic [HDATA_SIZE-1:0]   mem_din_o,
  output logic                    mem_we_o,
  output logic [HDATA_SIZE/8-1:0] mem_be_o,
  output logic [MEM_ABITS-1:0]    mem_raddr_o,
  input  logic [HDATA_SIZE-1:0]   mem_dout_i
);

  localparam int unsigned BYTES  = HDATA_SIZE / 8;
  localparam int unsigned BOFS   = $clog2(BYTES);
  localparam int unsigned BOFS_W = (BOFS > 0) ? BOFS : 1;

  state_t                 state_q, state_d;
  logic [MEM_ABITS-1:0]   addr_q;
  logic [BYTES-1:0]       be_q;
  logic [BYTES-1:0]       be_c;
  logic                   size_err_c;
  logic                   take_c;
  logic                   hazard_c;
  logic [MEM_ABITS-1:0]   word_c;
  logic                   unused;

  assign unused = ^{HBURST, HPROT, HADDR};

  mpsoc_ahb3_ram_be_gen #(
    .BYTES (BYTES),
    .OFS_W (BOFS_W)
  ) u_be_gen (
    .hsize    (HSIZE),
    .addr_lo  (HADDR[BOFS_W-1:0]),
    .be       (be_c),
    .size_err (size_err_c)
  );

  // Upper address bits are dropped, so addresses alias modulo the RAM size.
  assign word_c = HADDR[MEM_ABITS+BOFS-1:BOFS];
  assign take_c = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ))
                & (state_q != ST_STALL) & (state_q != ST_ERR1);
  assign hazard_c = (state_q == ST_WR) & take_c & ~HWRITE & ~size_err_c
                  & (word_c == addr_q) & (|(be_c & be_q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STALL: state_d = ST_RD;
      ST_ERR1:  state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (take_c) begin
          if (size_err_c)  state_d = ST_ERR1;
          else if (HWRITE) state_d = ST_WR;
`ifdef MPSOC_AHB3_RAM_BRIDGE_BYPASS_EN
          else             state_d = ST_RD;
`else
          else if (hazard_c) state_d = ST_STALL;
          else               state_d = ST_RD;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      be_q   <= '0;
    end else if (take_c) begin
      addr_q <= word_c;
      be_q   <= be_c;
    end
  end

  assign mem_we_o    = (state_q == ST_WR);
  assign mem_be_o    = mem_we_o ? be_q : '0;
  assign mem_waddr_o = addr_q;
  assign mem_din_o   = HWDATA;
  assign mem_raddr_o = (state_q == ST_STALL) ? addr_q : word_c;
  assign HREADYOUT   = (state_q != ST_STALL) & (state_q != ST_ERR1);
  assign HRESP       = ((state_q == ST_ERR1) | (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

`ifdef MPSOC_AHB3_RAM_BRIDGE_BYPASS_EN
  logic [HDATA_SIZE-1:0] byp_data_q;
  logic [BYTES-1:0]      byp_be_q;
  logic                  byp_hit_q;

  // Capture the committing write so the hazarding read can merge it in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byp_data_q <= '0;
      byp_be_q   <= '0;
      byp_hit_q  <= 1'b0;
    end else begin
      byp_hit_q <= hazard_c;
      if (state_q == ST_WR) begin
        byp_data_q <= HWDATA;
        byp_be_q   <= be_q;
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (state_q == ST_RD) begin
      HRDATA = mem_dout_i;
      if (byp_hit_q) begin
        for (int i = 0; i < int'(BYTES); i++) begin
          if (byp_be_q[i]) HRDATA[i*8 +: 8] = byp_data_q[i*8 +: 8];
        end
      end
    end
  end
`else
  assign HRDATA = (state_q == ST_RD) ? mem_dout_i : '0;
`endif

endmodule
